// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin packet arbiter sharing one UART transmitter write
//            port, with full-flag backpressure and a starvation watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          data_write_o,
  input  logic                          data_buffer_full_i,
  output logic                          timeout_o,
  output logic [$clog2(NUM_REQ)-1:0]    timeout_id_o
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam logic [CNT_WIDTH-1:0] C_TIMEOUT   = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [ID_WIDTH-1:0]  C_LAST_INIT = ID_WIDTH'(NUM_REQ - 1);
  localparam logic                 C_WDOG_EN   = (TIMEOUT_CYCLES != 0);

  logic [0:0]           state_q,      state_d;
  logic [NUM_REQ-1:0]   grant_q,      grant_d;
  logic [ID_WIDTH-1:0]  owner_q,      owner_d;
  logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] wdog_q,       wdog_d;
  logic                 timeout_q,    timeout_d;
  logic [ID_WIDTH-1:0]  timeout_id_q, timeout_id_d;

  logic                 in_xfer;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 xfer_fire;
  logic                 starving;
  logic                 wdog_expire;
  logic [CNT_WIDTH-1:0] wdog_inc;
  logic                 pick_found;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic [ID_WIDTH-1:0]  cand;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_bytes[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(last_grant_q) + i) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign in_xfer     = (state_q == ST_XFER);
  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign xfer_fire   = in_xfer & owner_valid & ~data_buffer_full_i;
  // A full transmitter is not the requester's fault, so it never feeds the watchdog.
  assign starving    = in_xfer & ~owner_valid & ~data_buffer_full_i;
  assign wdog_inc    = wdog_q + CNT_WIDTH'(1);
  assign wdog_expire = C_WDOG_EN & starving & (wdog_inc == C_TIMEOUT);

  assign req_ready_o  = grant_q & {NUM_REQ{~data_buffer_full_i}};
  assign data_write_o = xfer_fire;
  assign data_o       = xfer_fire ? req_bytes[owner_q] : '0;
  assign grant_o      = grant_q;
  assign busy_o       = in_xfer;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (pick_found) begin
          state_d = ST_XFER;
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
        end
      end
      ST_XFER: begin
        if (xfer_fire) begin
          wdog_d = '0;
          if (owner_last) begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            last_grant_d = owner_q;
          end
        end else if (wdog_expire) begin
          wdog_d       = '0;
          state_d      = ST_IDLE;
          grant_d      = '0;
          last_grant_d = owner_q;
          timeout_d    = 1'b1;
          timeout_id_d = owner_q;
        end else if (C_WDOG_EN && starving) begin
          wdog_d = wdog_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= C_LAST_INIT;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

endmodule
`default_nettype wire
